// File: rtl/or1200_core_pkg.sv
// Shared constants and types for the reduced OR1200 core slice.
package or1200_core_pkg;

    localparam logic [31:0] OR1200_RESET_VEC  = 32'h0000_0100;
    localparam logic [31:0] OR1200_BUSERR_VEC = 32'h0000_0200;

    localparam logic [5:0]  OP_J    = 6'h00;

    localparam logic [15:0] SPR_NPC = 16'h0010;
    localparam logic [15:0] SPR_PPC = 16'h0012;

    localparam logic [1:0]  DBG_IS_NONE  = 2'b00;
    localparam logic [1:0]  DBG_IS_OTHER = 2'b01;
    localparam logic [1:0]  DBG_IS_JUMP  = 2'b10;
    localparam logic [1:0]  DBG_IS_DELAY = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2
    } fetch_state_t;

    // Sign-extended, word-scaled l.j displacement.
    function automatic logic [31:0] j_offset(input logic [25:0] imm);
        return {{4{imm[25]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/or1200_core_fetch.sv
// Instruction-fetch engine: classic Wishbone master, PC / PPC and l.j delay-slot tracking.
module or1200_core_fetch
    import or1200_core_pkg::*;
#(
    parameter logic [31:0] RESET_VEC  = OR1200_RESET_VEC,
    parameter logic [31:0] BUSERR_VEC = OR1200_BUSERR_VEC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic [31:0] iwb_dat_i,
    input  logic        iwb_ack_i,
    input  logic        iwb_err_i,
    input  logic        iwb_rty_i,
    input  logic        npc_we,
    input  logic [31:0] npc_dat,
    output logic        iwb_cyc_o,
    output logic        iwb_stb_o,
    output logic [31:0] iwb_adr_o,
    output logic [31:0] pc_o,
    output logic [31:0] ppc_o,
    output logic [1:0]  dbg_is_o
);

    fetch_state_t state, state_nxt;
    logic [31:0]  pc, ppc, insn, jmp_tgt;
    logic         jmp_pend;

    assign iwb_stb_o = iwb_cyc_o;
    assign iwb_adr_o = pc;
    assign pc_o      = pc;
    assign ppc_o     = ppc;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next-state, bus strobes and instruction-status decode.
    always_comb begin
        state_nxt = state;
        iwb_cyc_o = 1'b0;
        dbg_is_o  = DBG_IS_NONE;
        case (state)
            ST_IDLE: begin
                if (!stall) state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                iwb_cyc_o = 1'b1;
                if (iwb_err_i)      state_nxt = ST_IDLE;
                else if (iwb_ack_i) state_nxt = ST_EXEC;
                else if (iwb_rty_i) state_nxt = ST_IDLE;
            end
            ST_EXEC: begin
                state_nxt = ST_IDLE;
                if (jmp_pend)                dbg_is_o = DBG_IS_DELAY;
                else if (insn[31:26] == OP_J) dbg_is_o = DBG_IS_JUMP;
                else                          dbg_is_o = DBG_IS_OTHER;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // PC, PPC, instruction latch and pending-jump bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc       <= RESET_VEC;
            ppc      <= '0;
            insn     <= '0;
            jmp_tgt  <= '0;
            jmp_pend <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (stall && npc_we) begin
                        pc       <= npc_dat;
                        jmp_pend <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    if (iwb_err_i) begin
                        pc       <= BUSERR_VEC;
                        jmp_pend <= 1'b0;
                    end else if (iwb_ack_i) begin
                        insn <= iwb_dat_i;
                    end
                end
                ST_EXEC: begin
                    ppc <= pc;
                    // The pending check comes first so a l.j in a delay slot is a nop.
                    if (jmp_pend) begin
                        pc       <= jmp_tgt;
                        jmp_pend <= 1'b0;
                    end else if (insn[31:26] == OP_J) begin
                        jmp_tgt  <= pc + j_offset(insn[25:0]);
                        jmp_pend <= 1'b1;
                        pc       <= pc + 32'd4;
                    end else begin
                        pc <= pc + 32'd4;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/or1200_core_top.sv
// Reduced OR1200 CPU top: fetch engine plus debug SPR port, PM/PIC stubs and idle data bus.
module or1200_core_top #(
    parameter logic [31:0] RESET_VEC  = or1200_core_pkg::OR1200_RESET_VEC,
    parameter logic [31:0] BUSERR_VEC = or1200_core_pkg::OR1200_BUSERR_VEC
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [1:0]  clmode_i,
    input  logic [19:0] pic_ints_i,

    input  logic        iwb_clk_i,
    input  logic        iwb_rst_i,
    input  logic        iwb_ack_i,
    input  logic        iwb_err_i,
    input  logic        iwb_rty_i,
    input  logic [31:0] iwb_dat_i,
    output logic        iwb_cyc_o,
    output logic [31:0] iwb_adr_o,
    output logic        iwb_stb_o,
    output logic        iwb_we_o,
    output logic [3:0]  iwb_sel_o,
    output logic [31:0] iwb_dat_o,
`ifdef OR1200_WB_CAB
    output logic        iwb_cab_o,
`endif

    input  logic        dwb_clk_i,
    input  logic        dwb_rst_i,
    input  logic        dwb_ack_i,
    input  logic        dwb_err_i,
    input  logic        dwb_rty_i,
    input  logic [31:0] dwb_dat_i,
    output logic        dwb_cyc_o,
    output logic [31:0] dwb_adr_o,
    output logic        dwb_stb_o,
    output logic        dwb_we_o,
    output logic [3:0]  dwb_sel_o,
    output logic [31:0] dwb_dat_o,
`ifdef OR1200_WB_CAB
    output logic        dwb_cab_o,
`endif

    input  logic        dbg_stall_i,
    input  logic        dbg_ewt_i,
    output logic [3:0]  dbg_lss_o,
    output logic [1:0]  dbg_is_o,
    output logic [10:0] dbg_wp_o,
    output logic        dbg_bp_o,
    input  logic        dbg_stb_i,
    input  logic        dbg_we_i,
    input  logic [31:0] dbg_adr_i,
    input  logic [31:0] dbg_dat_i,
    output logic [31:0] dbg_dat_o,
    output logic        dbg_ack_o,

    input  logic        pm_cpustall_i,
    output logic [3:0]  pm_clksd_o,
    output logic        pm_dc_gate_o,
    output logic        pm_ic_gate_o,
    output logic        pm_dmmu_gate_o,
    output logic        pm_immu_gate_o,
    output logic        pm_tt_gate_o,
    output logic        pm_cpu_gate_o,
    output logic        pm_wakeup_o,
    output logic        pm_lvolt_o
);
    import or1200_core_pkg::*;

    logic        rst;
    logic        stall;
    logic        dbg_start;
    logic        npc_we;
    logic [31:0] pc, ppc, spr_rdata;
    logic        unused_ok;

    assign rst   = rst_i | iwb_rst_i | dwb_rst_i;
    assign stall = dbg_stall_i | pm_cpustall_i;

    or1200_core_fetch #(
        .RESET_VEC  (RESET_VEC),
        .BUSERR_VEC (BUSERR_VEC)
    ) u_fetch (
        .clk       (clk_i),
        .rst       (rst),
        .stall     (stall),
        .iwb_dat_i (iwb_dat_i),
        .iwb_ack_i (iwb_ack_i),
        .iwb_err_i (iwb_err_i),
        .iwb_rty_i (iwb_rty_i),
        .npc_we    (npc_we),
        .npc_dat   (dbg_dat_i),
        .iwb_cyc_o (iwb_cyc_o),
        .iwb_stb_o (iwb_stb_o),
        .iwb_adr_o (iwb_adr_o),
        .pc_o      (pc),
        .ppc_o     (ppc),
        .dbg_is_o  (dbg_is_o)
    );

    assign iwb_we_o  = 1'b0;
    assign iwb_sel_o = 4'hF;
    assign iwb_dat_o = '0;

    assign dwb_cyc_o = 1'b0;
    assign dwb_adr_o = '0;
    assign dwb_stb_o = 1'b0;
    assign dwb_we_o  = 1'b0;
    assign dwb_sel_o = 4'hF;
    assign dwb_dat_o = '0;
`ifdef OR1200_WB_CAB
    assign iwb_cab_o = 1'b0;
    assign dwb_cab_o = 1'b0;
`endif

    assign dbg_lss_o = '0;
    assign dbg_wp_o  = '0;
    assign dbg_bp_o  = 1'b0;

    assign pm_clksd_o     = '0;
    assign pm_dc_gate_o   = 1'b0;
    assign pm_ic_gate_o   = 1'b0;
    assign pm_dmmu_gate_o = 1'b0;
    assign pm_immu_gate_o = 1'b0;
    assign pm_tt_gate_o   = 1'b0;
    assign pm_cpu_gate_o  = 1'b0;
    assign pm_lvolt_o     = 1'b0;

    // A debug access starts on a strobe not already being acknowledged.
    assign dbg_start = dbg_stb_i & ~dbg_ack_o;
    assign npc_we    = dbg_start & dbg_we_i & (dbg_adr_i[15:0] == SPR_NPC);

    // SPR read mux; unmapped addresses read as zero.
    always_comb begin
        spr_rdata = '0;
        case (dbg_adr_i[15:0])
            SPR_NPC: spr_rdata = pc;
            SPR_PPC: spr_rdata = ppc;
            default: spr_rdata = '0;
        endcase
    end

    // Debug acknowledge and read data, one clock after the access starts.
    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            dbg_ack_o <= 1'b0;
            dbg_dat_o <= '0;
        end else begin
            dbg_ack_o <= dbg_start;
            dbg_dat_o <= (dbg_start && !dbg_we_i) ? spr_rdata : '0;
        end
    end

    // Registered wakeup request from any interrupt line.
    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) pm_wakeup_o <= 1'b0;
        else     pm_wakeup_o <= |pic_ints_i;
    end

    assign unused_ok = ^{iwb_clk_i, dwb_clk_i, clmode_i, dbg_ewt_i, dbg_adr_i[31:16],
                         dwb_ack_i, dwb_err_i, dwb_rty_i, dwb_dat_i};

endmodule

// File: tb/tb_or1200_core_top.sv
// Self-checking bench for or1200_core_top: vector table, randomized fetch traffic, debug/PM sequences.
module tb_or1200_core_top;

    localparam logic [31:0] RST_VEC = 32'h0000_0100;
    localparam logic [31:0] ERR_VEC = 32'h0000_0200;
    localparam logic [31:0] NOP     = 32'h1500_0000;

    localparam int R_ACK = 0;
    localparam int R_RTY = 1;
    localparam int R_ERR = 2;

    logic        clk = 1'b0;
    logic        rst_i = 1'b0;
    logic [1:0]  clmode_i = 2'b00;
    logic [19:0] pic_ints_i = '0;
    logic        iwb_rst_i = 1'b0, iwb_ack_i = 1'b0, iwb_err_i = 1'b0, iwb_rty_i = 1'b0;
    logic [31:0] iwb_dat_i = '0;
    logic        iwb_cyc_o, iwb_stb_o, iwb_we_o;
    logic [31:0] iwb_adr_o, iwb_dat_o;
    logic [3:0]  iwb_sel_o;
    logic        dwb_rst_i = 1'b0, dwb_ack_i = 1'b0, dwb_err_i = 1'b0, dwb_rty_i = 1'b0;
    logic [31:0] dwb_dat_i = '0;
    logic        dwb_cyc_o, dwb_stb_o, dwb_we_o;
    logic [31:0] dwb_adr_o, dwb_dat_o;
    logic [3:0]  dwb_sel_o;
    logic        dbg_stall_i = 1'b0, dbg_ewt_i = 1'b0, dbg_stb_i = 1'b0, dbg_we_i = 1'b0;
    logic [31:0] dbg_adr_i = '0, dbg_dat_i = '0;
    logic [3:0]  dbg_lss_o;
    logic [1:0]  dbg_is_o;
    logic [10:0] dbg_wp_o;
    logic        dbg_bp_o, dbg_ack_o;
    logic [31:0] dbg_dat_o;
    logic        pm_cpustall_i = 1'b0;
    logic [3:0]  pm_clksd_o;
    logic        pm_dc_gate_o, pm_ic_gate_o, pm_dmmu_gate_o, pm_immu_gate_o;
    logic        pm_tt_gate_o, pm_cpu_gate_o, pm_wakeup_o, pm_lvolt_o;

    always #5 clk = ~clk;

    or1200_core_top #(
        .RESET_VEC  (RST_VEC),
        .BUSERR_VEC (ERR_VEC)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .clmode_i(clmode_i), .pic_ints_i(pic_ints_i),
        .iwb_clk_i(clk), .iwb_rst_i(iwb_rst_i), .iwb_ack_i(iwb_ack_i), .iwb_err_i(iwb_err_i),
        .iwb_rty_i(iwb_rty_i), .iwb_dat_i(iwb_dat_i), .iwb_cyc_o(iwb_cyc_o), .iwb_adr_o(iwb_adr_o),
        .iwb_stb_o(iwb_stb_o), .iwb_we_o(iwb_we_o), .iwb_sel_o(iwb_sel_o), .iwb_dat_o(iwb_dat_o),
        .dwb_clk_i(clk), .dwb_rst_i(dwb_rst_i), .dwb_ack_i(dwb_ack_i), .dwb_err_i(dwb_err_i),
        .dwb_rty_i(dwb_rty_i), .dwb_dat_i(dwb_dat_i), .dwb_cyc_o(dwb_cyc_o), .dwb_adr_o(dwb_adr_o),
        .dwb_stb_o(dwb_stb_o), .dwb_we_o(dwb_we_o), .dwb_sel_o(dwb_sel_o), .dwb_dat_o(dwb_dat_o),
        .dbg_stall_i(dbg_stall_i), .dbg_ewt_i(dbg_ewt_i), .dbg_lss_o(dbg_lss_o), .dbg_is_o(dbg_is_o),
        .dbg_wp_o(dbg_wp_o), .dbg_bp_o(dbg_bp_o), .dbg_stb_i(dbg_stb_i), .dbg_we_i(dbg_we_i),
        .dbg_adr_i(dbg_adr_i), .dbg_dat_i(dbg_dat_i), .dbg_dat_o(dbg_dat_o), .dbg_ack_o(dbg_ack_o),
        .pm_cpustall_i(pm_cpustall_i), .pm_clksd_o(pm_clksd_o), .pm_dc_gate_o(pm_dc_gate_o),
        .pm_ic_gate_o(pm_ic_gate_o), .pm_dmmu_gate_o(pm_dmmu_gate_o), .pm_immu_gate_o(pm_immu_gate_o),
        .pm_tt_gate_o(pm_tt_gate_o), .pm_cpu_gate_o(pm_cpu_gate_o), .pm_wakeup_o(pm_wakeup_o),
        .pm_lvolt_o(pm_lvolt_o)
    );

    int checks = 0;
    int failures = 0;
    int static_bad = 0;
    logic mon_en = 1'b0;

    // Architectural reference state: program counter, previous PC, pending branch.
    logic [31:0] m_pc = RST_VEC, m_ppc = '0, m_tgt = '0;
    logic        m_pend = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Outputs that must never move.
    always @(negedge clk) begin
        if (mon_en) begin
            if (dwb_cyc_o || dwb_stb_o || dwb_we_o || dwb_adr_o != 0 || dwb_dat_o != 0 ||
                dwb_sel_o != 4'hF || iwb_we_o || iwb_sel_o != 4'hF || iwb_dat_o != 0 ||
                dbg_lss_o != 0 || dbg_wp_o != 0 || dbg_bp_o || pm_clksd_o != 0 ||
                pm_dc_gate_o || pm_ic_gate_o || pm_dmmu_gate_o || pm_immu_gate_o ||
                pm_tt_gate_o || pm_cpu_gate_o || pm_lvolt_o || iwb_stb_o != iwb_cyc_o)
                static_bad++;
        end
    end

    // Reference: expected fetch address and status for one bus termination.
    task automatic model_step(input int resp, input logic [31:0] insn,
                              output logic [31:0] adr, output logic [1:0] is);
        int off;
        adr = m_pc;
        is  = 2'b00;
        if (resp == R_ERR) begin
            m_pc   = ERR_VEC;
            m_pend = 1'b0;
        end else if (resp == R_ACK) begin
            m_ppc = m_pc;
            if (m_pend) begin
                is     = 2'b11;
                m_pc   = m_tgt;
                m_pend = 1'b0;
            end else if (insn[31:26] == 6'd0) begin
                is     = 2'b10;
                off    = int'($signed(insn[25:0])) * 4;
                m_tgt  = m_pc + 32'(off);
                m_pend = 1'b1;
                m_pc   = m_pc + 32'd4;
            end else begin
                is   = 2'b01;
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    task automatic wait_fetch();
        int n = 0;
        while (!iwb_cyc_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!iwb_cyc_o) begin
            failures++;
            $display("FAIL fetch_timeout: cyc=%0b after %0d cycles", iwb_cyc_o, n);
        end
    endtask

    // Complete one fetch; called and returns at a falling edge.
    task automatic transact(input int resp, input logic [31:0] dat, input logic [31:0] exp_adr,
                            input logic [1:0] exp_is, input int wait_n);
        wait_fetch();
        repeat (wait_n) @(negedge clk);
        chk("fetch_cyc", {31'd0, iwb_cyc_o}, 32'd1);
        chk("fetch_adr", iwb_adr_o, exp_adr);
        iwb_dat_i = dat;
        iwb_ack_i = (resp == R_ACK);
        iwb_rty_i = (resp == R_RTY);
        iwb_err_i = (resp == R_ERR);
        @(negedge clk);
        iwb_ack_i = 1'b0;
        iwb_rty_i = 1'b0;
        iwb_err_i = 1'b0;
        iwb_dat_i = $urandom;
        chk("cyc_drop", {31'd0, iwb_cyc_o}, 32'd0);
        chk("dbg_is", {30'd0, dbg_is_o}, {30'd0, exp_is});
    endtask

    task automatic dbg_access(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                              input logic [31:0] exp_rd);
        dbg_stb_i = 1'b1;
        dbg_we_i  = we;
        dbg_adr_i = adr;
        dbg_dat_i = wdat;
        @(negedge clk);
        chk("dbg_ack", {31'd0, dbg_ack_o}, 32'd1);
        if (!we) chk("dbg_rdata", dbg_dat_o, exp_rd);
        dbg_stb_i = 1'b0;
        dbg_we_i  = 1'b0;
        @(negedge clk);
        chk("dbg_ack_low", {31'd0, dbg_ack_o}, 32'd0);
        chk("dbg_dat_idle", dbg_dat_o, 32'd0);
    endtask

    typedef struct {
        int          resp;
        logic [31:0] dat;
        logic [31:0] exp_adr;
        logic [1:0]  exp_is;
    } vec_t;

    vec_t vecs[12];

    initial begin
        logic [31:0] e_adr;
        logic [1:0]  e_is;
        int          r, resp;
        logic [31:0] insn;

        vecs[0]  = '{R_ACK, NOP,          32'h100, 2'b01};
        vecs[1]  = '{R_ACK, NOP,          32'h104, 2'b01};
        vecs[2]  = '{R_ACK, 32'h0000_0004, 32'h108, 2'b10}; // target 0x118
        vecs[3]  = '{R_ACK, NOP,          32'h10C, 2'b11};
        vecs[4]  = '{R_ACK, 32'h03FF_FFFF, 32'h118, 2'b10}; // target 0x114
        vecs[5]  = '{R_ACK, NOP,          32'h11C, 2'b11};
        vecs[6]  = '{R_RTY, NOP,          32'h114, 2'b00};
        vecs[7]  = '{R_ERR, NOP,          32'h114, 2'b00};
        vecs[8]  = '{R_ACK, NOP,          32'h200, 2'b01};
        vecs[9]  = '{R_ACK, 32'h0000_0000, 32'h204, 2'b10}; // target 0x204
        vecs[10] = '{R_ACK, 32'h0000_0008, 32'h208, 2'b11}; // l.j in slot: nop
        vecs[11] = '{R_ACK, NOP,          32'h204, 2'b01};

        #200 rst_i = 1'b1;
        #50;
        chk("rst_cyc", {31'd0, iwb_cyc_o}, 32'd0);
        chk("rst_adr", iwb_adr_o, RST_VEC);
        chk("rst_sel", {28'd0, iwb_sel_o}, 32'hF);
        chk("rst_dbg_ack", {31'd0, dbg_ack_o}, 32'd0);
        chk("rst_wakeup", {31'd0, pm_wakeup_o}, 32'd0);
        #50 rst_i = 1'b0;
        mon_en = 1'b1;
        #8;
        @(negedge clk);
        chk("first_cyc", {31'd0, iwb_cyc_o}, 32'd1);
        chk("first_adr", iwb_adr_o, RST_VEC);
        repeat (5) @(negedge clk);
        chk("hold_cyc", {31'd0, iwb_cyc_o}, 32'd1);
        chk("hold_adr", iwb_adr_o, RST_VEC);

        for (int i = 0; i < 12; i++) begin
            model_step(vecs[i].resp, vecs[i].dat, e_adr, e_is);
            transact(vecs[i].resp, vecs[i].dat, vecs[i].exp_adr, vecs[i].exp_is, i % 3);
        end

        for (int i = 0; i < 60; i++) begin
            r    = $urandom_range(0, 9);
            resp = (r < 7) ? R_ACK : ((r < 9) ? R_RTY : R_ERR);
            if ($urandom_range(0, 2) == 0) insn = {6'h00, 26'($urandom)};
            else                           insn = {6'($urandom_range(1, 63)), 26'($urandom)};
            model_step(resp, insn, e_adr, e_is);
            transact(resp, insn, e_adr, e_is, $urandom_range(0, 2));
        end

        // Debug halt and SPR access.
        dbg_stall_i = 1'b1;
        repeat (2) @(negedge clk);
        chk("stall_idle", {31'd0, iwb_cyc_o}, 32'd0);
        dbg_access(1'b0, 32'h0000_0010, 32'd0, m_pc);
        dbg_access(1'b0, 32'h0000_0012, 32'd0, m_ppc);
        dbg_access(1'b1, 32'h0000_0010, 32'h0000_2000, 32'd0);
        m_pc   = 32'h0000_2000;
        m_pend = 1'b0;
        dbg_access(1'b0, 32'hFFFF_0010, 32'd0, 32'h0000_2000);
        dbg_access(1'b1, 32'h0000_0012, 32'h0000_0055, 32'd0);
        dbg_access(1'b0, 32'h0000_0012, 32'd0, m_ppc);
        dbg_access(1'b0, 32'h0000_0020, 32'd0, 32'd0);
        chk("stall_hold", {31'd0, iwb_cyc_o}, 32'd0);
        dbg_stall_i = 1'b0;
        model_step(R_ACK, NOP, e_adr, e_is);
        transact(R_ACK, NOP, e_adr, e_is, 0);

        // Stall raised mid-fetch must not abort it; NPC write outside halt is dropped.
        wait_fetch();
        pm_cpustall_i = 1'b1;
        repeat (2) @(negedge clk);
        chk("stall_no_abort", {31'd0, iwb_cyc_o}, 32'd1);
        dbg_access(1'b1, 32'h0000_0010, 32'h0000_3000, 32'd0);
        model_step(R_ACK, NOP, e_adr, e_is);
        transact(R_ACK, NOP, e_adr, e_is, 0);
        repeat (3) @(negedge clk);
        chk("pm_stall_idle", {31'd0, iwb_cyc_o}, 32'd0);
        pm_cpustall_i = 1'b0;
        model_step(R_ACK, NOP, e_adr, e_is);
        transact(R_ACK, NOP, e_adr, e_is, 0);

        // Wakeup request.
        pic_ints_i = 20'h00001;
        @(negedge clk);
        chk("wakeup_set", {31'd0, pm_wakeup_o}, 32'd1);
        pic_ints_i = 20'h00000;
        @(negedge clk);
        chk("wakeup_clr", {31'd0, pm_wakeup_o}, 32'd0);
        pic_ints_i = 20'h80000;
        @(negedge clk);
        chk("wakeup_hi", {31'd0, pm_wakeup_o}, 32'd1);
        pic_ints_i = '0;

        // Asynchronous reset through the bus reset in the middle of a fetch.
        wait_fetch();
        #2 iwb_rst_i = 1'b1;
        #1;
        chk("async_cyc", {31'd0, iwb_cyc_o}, 32'd0);
        chk("async_stb", {31'd0, iwb_stb_o}, 32'd0);
        chk("async_adr", iwb_adr_o, RST_VEC);
        @(negedge clk);
        iwb_rst_i = 1'b0;
        m_pc   = RST_VEC;
        m_ppc  = '0;
        m_pend = 1'b0;
        model_step(R_ACK, NOP, e_adr, e_is);
        transact(R_ACK, NOP, e_adr, e_is, 0);
        dbg_stall_i = 1'b1;
        repeat (2) @(negedge clk);
        dbg_access(1'b0, 32'h0000_0012, 32'd0, m_ppc);

        chk("static_ties", 32'(static_bad), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
